// File: rtl/regfile_scoreboard.sv
// Register file with N combinational read ports, one write port,
// optional write-to-read bypass, hard-wired zero register and busy scoreboard.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       reg_write,
  input  logic                       reg_dest,
  input  logic [ADDR_W-1:0]          wr_addr_a,
  input  logic [ADDR_W-1:0]          wr_addr_b,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_addr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic [ADDR_W-1:0] w_wa;
  logic              w_wr_en;
  logic              w_iss_en;

  assign w_wa     = reg_dest ? wr_addr_b : wr_addr_a;
  assign w_wr_en  = reg_write &&
                    !((ZERO_REG != 0) && (w_wa == '0));
  assign w_iss_en = iss_valid &&
                    !((ZERO_REG != 0) && (iss_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_rf[k] <= '0;
    end else if (w_wr_en) begin
      r_rf[w_wa] <= wr_data;
    end
  end

  // Issue is applied after the write clear so a new producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (w_wr_en)  r_busy[w_wa]     <= 1'b0;
      if (w_iss_en) r_busy[iss_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_d;
    logic              w_b;
    logic              w_hit;
    logic              w_zero;

    assign w_ra   = rd_addr[g*ADDR_W +: ADDR_W];
    assign w_hit  = (BYPASS != 0) && w_wr_en && (w_wa == w_ra);
    // Reset also masks the bypass path so nothing leaks while held.
    assign w_zero = !rst_n ||
                    ((ZERO_REG != 0) && (w_ra == '0));

    always_comb begin
      w_d = r_rf[w_ra];
      w_b = r_busy[w_ra];
      if (w_hit) begin
        w_d = wr_data;
        w_b = 1'b0;
      end
      if (w_zero) begin
        w_d = '0;
        w_b = 1'b0;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = w_d;
    assign rd_busy[g]                  = w_b;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypass and non-bypass instances share
// stimulus; expected read values are queued at drive time and popped at check.
`timescale 1ns/1ps
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_data;
  logic [1:0]  rd_busy, nb_busy;
  logic        reg_write, reg_dest, iss_valid;
  logic [4:0]  wr_addr_a, wr_addr_b, iss_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  regfile_scoreboard #(.BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .reg_write(reg_write), .reg_dest(reg_dest),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  regfile_scoreboard #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(nb_data), .rd_busy(nb_busy),
    .reg_write(reg_write), .reg_dest(reg_dest),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  typedef struct {
    logic        we;
    logic        dest;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] nd0;
    logic        nb0;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] nd0;
    logic        nb0;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic we, input logic dest,
    input logic [4:0] a, input logic [4:0] b,
    input logic [31:0] wd,
    input logic iv, input logic [4:0] ia,
    input logic [4:0] r0, input logic [4:0] r1,
    input logic [31:0] d0, input logic b0,
    input logic [31:0] d1, input logic b1,
    input logic [31:0] nd0, input logic nb0);
    vec_t v;
    v.we = we; v.dest = dest; v.a = a; v.b = b;
    v.wd = wd; v.iv = iv; v.ia = ia;
    v.r0 = r0; v.r1 = r1;
    v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
    v.nd0 = nd0; v.nb0 = nb0;
    return v;
  endfunction

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d0, input logic b0,
                      input logic [31:0] d1, input logic b1,
                      input logic [31:0] nd0, input logic nb0);
    exp_t e;
    e.d0 = d0; e.b0 = b0; e.d1 = d1; e.b1 = b1;
    e.nd0 = nd0; e.nb0 = nb0;
    q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s scoreboard empty got 0 want 1", tag);
      return;
    end
    e = q.pop_front();
    cmp({tag, ".d0"}, rd_data[31:0], e.d0);
    cmp({tag, ".b0"}, 32'(rd_busy[0]), 32'(e.b0));
    cmp({tag, ".d1"}, rd_data[63:32], e.d1);
    cmp({tag, ".b1"}, 32'(rd_busy[1]), 32'(e.b1));
    cmp({tag, ".nd0"}, nb_data[31:0], e.nd0);
    cmp({tag, ".nb0"}, 32'(nb_busy[0]), 32'(e.nb0));
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reg_write = v.we;  reg_dest  = v.dest;
    wr_addr_a = v.a;   wr_addr_b = v.b;
    wr_data   = v.wd;
    iss_valid = v.iv;  iss_addr  = v.ia;
    rd_addr   = {v.r1, v.r0};
    push(v.d0, v.b0, v.d1, v.b1, v.nd0, v.nb0);
    #2 pop_check($sformatf("vec%0d", idx));
  endtask

  task automatic idle();
    reg_write = 1'b0; reg_dest = 1'b0;
    wr_addr_a = '0; wr_addr_b = '0; wr_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  initial begin
    // we dst  a      b      wdata         iv ia     r0     r1
    //   d0            b0    d1            b1    nd0           nb0
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd8,5'd23,
      32'h0,1'b0,32'h0,1'b0,32'h0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,5'd9,5'd17,32'hDEADBEEF,1'b0,5'd0,5'd17,5'd9,
      32'hDEADBEEF,1'b0,32'h0,1'b0,32'h0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd17,5'd9,
      32'hDEADBEEF,1'b0,32'h0,1'b0,32'hDEADBEEF,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'd9,5'd17,32'hCAFEF00D,1'b0,5'd0,5'd9,5'd17,
      32'hCAFEF00D,1'b0,32'hDEADBEEF,1'b0,32'h0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd9,5'd17,
      32'hCAFEF00D,1'b0,32'hDEADBEEF,1'b0,32'hCAFEF00D,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'd10,5'd0,32'h12345678,1'b0,5'd0,5'd10,5'd10,
      32'h12345678,1'b0,32'h12345678,1'b0,32'h0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd10,5'd10,
      32'h12345678,1'b0,32'h12345678,1'b0,32'h12345678,1'b0));
    tbl.push_back(mk(1'b1,1'b1,5'd3,5'd0,32'hFFFFFFFF,1'b1,5'd0,5'd0,5'd0,
      32'h0,1'b0,32'h0,1'b0,32'h0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0,
      32'h0,1'b0,32'h0,1'b0,32'h0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b1,5'd16,5'd16,5'd16,
      32'h0,1'b0,32'h0,1'b0,32'h0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd16,5'd16,
      32'h0,1'b1,32'h0,1'b1,32'h0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,5'd16,5'd0,32'h11112222,1'b0,5'd0,5'd16,5'd16,
      32'h11112222,1'b0,32'h11112222,1'b0,32'h0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd16,5'd16,
      32'h11112222,1'b0,32'h11112222,1'b0,32'h11112222,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b1,5'd16,5'd16,5'd16,
      32'h11112222,1'b0,32'h11112222,1'b0,32'h11112222,1'b0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd16,5'd16,
      32'h11112222,1'b1,32'h11112222,1'b1,32'h11112222,1'b1));
    tbl.push_back(mk(1'b1,1'b0,5'd16,5'd0,32'h33334444,1'b1,5'd16,5'd16,5'd16,
      32'h33334444,1'b0,32'h33334444,1'b0,32'h11112222,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd16,5'd16,
      32'h33334444,1'b1,32'h33334444,1'b1,32'h33334444,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b1,5'd16,5'd16,5'd16,
      32'h33334444,1'b1,32'h33334444,1'b1,32'h33334444,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd16,5'd16,
      32'h33334444,1'b1,32'h33334444,1'b1,32'h33334444,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b1,5'd12,5'd12,5'd16,
      32'h0,1'b0,32'h33334444,1'b1,32'h0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'd12,5'd0,32'hA5A5A5A5,1'b1,5'd12,5'd12,5'd12,
      32'hA5A5A5A5,1'b0,32'hA5A5A5A5,1'b0,32'h0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,32'h0,1'b0,5'd0,5'd12,5'd3,
      32'hA5A5A5A5,1'b1,32'h0,1'b0,32'hA5A5A5A5,1'b1));

    rst_n = 1'b0;
    idle();
    rd_addr = '0;

    // Reset held: random reads must all return zero, not busy.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_addr = {5'($urandom_range(31)), 5'($urandom_range(31))};
      reg_write = 1'b1;
      wr_addr_a = rd_addr[4:0];
      wr_data = 32'hBAD0BAD0;
      push(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #2 pop_check($sformatf("rst%0d", i));
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Async reset between edges, with a write to reg 12 pending.
    @(negedge clk);
    idle();
    rd_addr = {5'd16, 5'd12};
    push(32'hA5A5A5A5, 1'b1, 32'h33334444, 1'b1, 32'hA5A5A5A5, 1'b1);
    #2 pop_check("pre_arst");
    reg_write = 1'b1;
    wr_addr_a = 5'd12;
    wr_data = 32'h5A5A5A5A;
    #1 rst_n = 1'b0;
    push(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 pop_check("arst");
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    push(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2 pop_check("post_arst");

    cmp("sb_drain", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised, clocked successor to the processor's register file. It provides NUM_RD combinational read ports and one synchronous write port, with the write destination selected between two candidate fields by reg_dest. It also has optional write-to-read bypass, a hard-wired zero register, and a per-register busy scoreboard. The scoreboard lets the control unit detect read-after-write hazards instead of relying on inserted delays. It sits between decode (read addresses, issue) and writeback (write data).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = visible next cycle
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way as rd_addr
- rd_busy  out  NUM_RD  1 = addressed register has a pending producer
- reg_write  in  1  write enable
- reg_dest  in  1  0 = write to wr_addr_a (rt field), 1 = write to wr_addr_b (rd field)
- wr_addr_a  in  ADDR_W  write candidate A
- wr_addr_b  in  ADDR_W  write candidate B
- wr_data  in  DATA_W  write data
- iss_valid  in  1  an instruction issues with a destination; mark busy
- iss_addr  in  ADDR_W  destination of the issuing instruction

## Operation
- Write address: wa = reg_dest ? wr_addr_b : wr_addr_a.
- Write: when reg_write=1, rf[wa] <= wr_data at the rising edge; rf[wa] <= wr_data and busy[wa] <= 0.
- Write with ZERO_REG=1 and wa=0: both updates are dropped; rf[0] stays 0.
- Read is combinational: rd_data[i] = rf[rd_addr[i]].
- Bypass (BYPASS=1): if reg_write=1 and wa==rd_addr[i] (and wa is not the zero register), then rd_data[i] = wr_data and rd_busy[i] = 0 in the same cycle.
- No bypass (BYPASS=0): a write is visible on rd_data only from the cycle after the edge.
- Read of zero register (ZERO_REG=1, rd_addr[i]=0): rd_data[i]=0 and rd_busy[i]=0 regardless of other inputs.
- Issue: iss_valid=1 sets busy[iss_addr] at the edge. Ignored for register 0 when ZERO_REG=1.
- Same-edge conflict: write clears and issue sets the same register; set wins, so busy=1 (a new producer). The data write still occurs.
- Issue to a register that is already busy: busy stays 1 (no counting; a single outstanding producer per register is assumed by control).
- Multiple read ports may address the same register; each returns identical data and busy.
- Reset: all rf entries and all busy bits go to 0 immediately on rst_n low and hold while low. Consequently rd_data=0 and rd_busy=0 during reset. Reset asserted mid-write cancels that write.

## Timing
- Read latency 0 cycles (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write latency 1 edge to state; 0 cycles to rd_data with BYPASS=1, 1 cycle with BYPASS=0.
- Busy set: visible on rd_busy the cycle after iss_valid.
- Busy clear: visible the same cycle as the write with BYPASS=1, the next cycle with BYPASS=0.
- No handshake stalls inside the block; hazard stalls are decided by control from rd_busy.
- Address widths are exact. wr_data is stored unmodified; no sign or zero extension.

## Test plan
- Reset/defaults: drive rst_n=0 with random addresses → all rd_data=0, all rd_busy=0. Release reset, read regs 8..23 → 0.
- reg_dest mux: reg_write=1, wr_addr_a=9, wr_addr_b=17, wr_data=0xDEADBEEF, reg_dest=1 → after the edge, rf[17]=0xDEADBEEF and rf[9]=0. Repeat with reg_dest=0 → rf[9] written.
- Bypass: BYPASS=1, write 0x12345678 to reg 10 while rd_addr[0]=10 → rd_data[0]=0x12345678 in the same cycle. BYPASS=0 → old value this cycle, new value next cycle.
- Zero register: write 0xFFFFFFFF to reg 0 and iss_valid to reg 0 → rd_data=0 and rd_busy=0 on all ports.
- Scoreboard: iss_valid to reg 16 → rd_busy=1 next cycle. Write reg 16 → busy clears. Same-edge write and issue to reg 16 → busy=1 and data updated.
- Async reset mid-operation: assert rst_n low between edges after writing reg 12=0xA5A5A5A5 with busy[12]=1 → rd_data=0 and rd_busy=0 immediately, without waiting for a clock edge.
